// File: rtl/cache_arbiter.sv
// Shares one cacheline memory port between icache and dcache, one transaction at a time.
module cache_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32,
  parameter bit          FAIR   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                last_d;
  logic                last_d_nxt;
  logic                read_nxt;
  logic                write_nxt;
  logic [ADDR_W-1:0]   address_nxt;
  logic [LINE_W-1:0]   wdata_nxt;
  logic                d_req;
  logic                grant_d;

  // Dcache wins a contended grant unless fairness passes the turn to the icache.
  assign d_req   = d_read | d_write;
  assign grant_d = d_req & ~(i_read & FAIR & last_d);

  // Next-state and latched transaction fields.
  always_comb begin
    state_nxt   = state;
    last_d_nxt  = last_d;
    read_nxt    = pmem_read;
    write_nxt   = pmem_write;
    address_nxt = pmem_address;
    wdata_nxt   = pmem_wdata;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt   = SERVE_D;
          last_d_nxt  = 1'b1;
          address_nxt = d_address;
          wdata_nxt   = d_wdata;
          write_nxt   = d_write;
          read_nxt    = ~d_write;
        end else if (i_read) begin
          state_nxt   = SERVE_I;
          last_d_nxt  = 1'b0;
          address_nxt = i_address;
          write_nxt   = 1'b0;
          read_nxt    = 1'b1;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_nxt = IDLE;
          read_nxt  = 1'b0;
          write_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        read_nxt  = 1'b0;
        write_nxt = 1'b0;
      end
    endcase
  end

  // State and latched request registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      state        <= state_nxt;
      last_d       <= last_d_nxt;
      pmem_read    <= read_nxt;
      pmem_write   <= write_nxt;
      pmem_address <= address_nxt;
      pmem_wdata   <= wdata_nxt;
    end
  end

  // Completion goes only to the granted cache; read data is a plain pass-through.
  assign i_resp  = (state == SERVE_I) & pmem_resp;
  assign d_resp  = (state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: two instances (fair / fixed priority), adaptor model, transaction-level reference.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read       [2];
  logic [31:0]  i_address    [2];
  logic [255:0] i_rdata      [2];
  logic         i_resp       [2];
  logic         d_read       [2];
  logic         d_write      [2];
  logic [31:0]  d_address    [2];
  logic [255:0] d_wdata      [2];
  logic [255:0] d_rdata      [2];
  logic         d_resp       [2];
  logic         pmem_read    [2];
  logic         pmem_write   [2];
  logic [31:0]  pmem_address [2];
  logic [255:0] pmem_wdata   [2];
  logic [255:0] pmem_rdata   [2];
  logic         pmem_resp    [2];

  int n_checks = 0;
  int n_errors = 0;

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .FAIR(1'b1)) u_fair (
    .clk(clk), .rst(rst),
    .i_read(i_read[0]), .i_address(i_address[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_address[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
    .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]), .pmem_address(pmem_address[0]),
    .pmem_wdata(pmem_wdata[0]), .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0])
  );

  cache_arbiter #(.LINE_W(256), .ADDR_W(32), .FAIR(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .i_read(i_read[1]), .i_address(i_address[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_address[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
    .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]), .pmem_address(pmem_address[1]),
    .pmem_wdata(pmem_wdata[1]), .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench control
  bit rand_en;
  bit lat_rand;
  bit hold_i;
  bit hold_d;
  int lat     [2];
  int cur_lat [2];
  int cnt     [2];

  // Reference model: one outstanding transaction per instance
  bit           m_busy   [2];
  bit           m_who_d  [2];
  bit           m_write  [2];
  bit           m_last_d [2];
  logic [31:0]  m_addr   [2];
  logic [255:0] m_wdata  [2];
  bit           glog0 [$];
  bit           glog1 [$];
  bit           rlog0 [$];

  // Directed-test statistics
  logic [31:0]  tgt_addr  [2];
  logic [255:0] tgt_wdata [2];
  int n_rd [2];
  int n_wr [2];
  int n_rd_hit [2];
  int n_wr_hit [2];
  int n_ir [2];
  int n_dr [2];

  task automatic check(input string nm, input int k, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Adaptor model: strobe held for L cycles, completion in the L-th
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        cnt[k] = 0;
        pmem_resp[k] = 1'b0;
      end else if (pmem_read[k] || pmem_write[k]) begin
        if (cnt[k] == 0) cur_lat[k] = lat_rand ? int'($urandom_range(1, 5)) : lat[k];
        cnt[k]++;
        pmem_resp[k] = (cnt[k] == cur_lat[k]);
        if (pmem_resp[k]) cnt[k] = 0;
      end else begin
        cnt[k] = 0;
        pmem_resp[k] = 1'b0;
      end
      pmem_rdata[k] = rand_line();
    end
  end

  // Reference model: grant decisions and transaction lifetime from the request rules
  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_busy[k] = 0; m_who_d[k] = 0; m_write[k] = 0; m_last_d[k] = 0;
        m_addr[k] = '0; m_wdata[k] = '0;
      end else if (m_busy[k]) begin
        if (pmem_resp[k]) m_busy[k] = 0;
      end else begin
        bit want_i, want_d, serve_d, fair;
        fair    = (k == 0);
        want_i  = i_read[k];
        want_d  = d_read[k] || d_write[k];
        serve_d = want_d && !(want_i && fair && m_last_d[k]);
        if (serve_d) begin
          m_busy[k] = 1; m_who_d[k] = 1; m_last_d[k] = 1;
          m_write[k] = d_write[k]; m_addr[k] = d_address[k]; m_wdata[k] = d_wdata[k];
        end else if (want_i) begin
          m_busy[k] = 1; m_who_d[k] = 0; m_last_d[k] = 0;
          m_write[k] = 0; m_addr[k] = i_address[k];
        end
        if (serve_d || want_i) begin
          if (k == 0) glog0.push_back(serve_d);
          else        glog1.push_back(serve_d);
        end
      end
    end
  end

  // Per-cycle compare, statistics, requester behaviour
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit e_rd, e_wr, e_ir, e_dr;
      e_rd = m_busy[k] && !m_write[k];
      e_wr = m_busy[k] && m_write[k];
      e_ir = m_busy[k] && !m_who_d[k] && pmem_resp[k];
      e_dr = m_busy[k] && m_who_d[k] && pmem_resp[k];
      check("pmem_read", k, pmem_read[k], e_rd);
      check("pmem_write", k, pmem_write[k], e_wr);
      check("pmem_address", k, pmem_address[k], m_addr[k]);
      check("pmem_wdata", k, pmem_wdata[k], m_wdata[k]);
      check("i_resp", k, i_resp[k], e_ir);
      check("d_resp", k, d_resp[k], e_dr);
      check("i_rdata", k, i_rdata[k], pmem_rdata[k]);
      check("d_rdata", k, d_rdata[k], pmem_rdata[k]);
      if (rst) begin
        n_rd[k] += int'(pmem_read[k]);
        n_wr[k] += int'(pmem_write[k]);
        if (pmem_read[k] && pmem_address[k] == tgt_addr[k]) n_rd_hit[k]++;
        if (pmem_write[k] && pmem_address[k] == tgt_addr[k] && pmem_wdata[k] == tgt_wdata[k]) n_wr_hit[k]++;
        n_ir[k] += int'(i_resp[k]);
        n_dr[k] += int'(d_resp[k]);
        if (k == 0 && i_resp[k]) rlog0.push_back(1'b0);
        if (k == 0 && d_resp[k]) rlog0.push_back(1'b1);
      end
      if (i_resp[k] && !hold_i) i_read[k] = 1'b0;
      if (d_resp[k] && !hold_d) begin d_read[k] = 1'b0; d_write[k] = 1'b0; end
      if (rand_en) begin
        if (!i_read[k] && $urandom_range(0, 3) == 0) begin
          i_read[k] = 1'b1; i_address[k] = $urandom;
        end else if (i_read[k] && $urandom_range(0, 1) == 0) begin
          i_address[k] = $urandom;
        end
        if (!d_read[k] && !d_write[k] && $urandom_range(0, 3) == 0) begin
          int op;
          op = int'($urandom_range(0, 7));
          d_write[k] = (op <= 3);
          d_read[k]  = (op == 0) || (op >= 4);
          d_address[k] = $urandom; d_wdata[k] = rand_line();
        end else if ((d_read[k] || d_write[k]) && $urandom_range(0, 1) == 0) begin
          d_address[k] = $urandom; d_wdata[k] = rand_line();
        end
      end
    end
  end

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      n_rd[k] = 0; n_wr[k] = 0; n_rd_hit[k] = 0; n_wr_hit[k] = 0; n_ir[k] = 0; n_dr[k] = 0;
    end
    glog0.delete(); glog1.delete(); rlog0.delete();
  endtask

  task automatic drop_all();
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b0; d_read[k] = 1'b0; d_write[k] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst = 1'b0;
    drop_all();
    for (int k = 0; k < 2; k++) begin pmem_resp[k] = 1'b0; cnt[k] = 0; end
    @(negedge clk); #1;
    rst = 1'b1;
    clear_stats();
  endtask

  task automatic wait_quiet(input int max_cycles);
    bit done;
    done = 0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk); #2;
      done = 1;
      for (int k = 0; k < 2; k++)
        if (m_busy[k] || i_read[k] || d_read[k] || d_write[k]) done = 0;
    end
    if (!done) check("timeout_quiet", 0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; rand_en = 0; lat_rand = 0; hold_i = 0; hold_d = 0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0; i_address[k] = '0; d_read[k] = 0; d_write[k] = 0;
      d_address[k] = '0; d_wdata[k] = '0; pmem_resp[k] = 0; pmem_rdata[k] = '0;
      lat[k] = 5; cur_lat[k] = 5; cnt[k] = 0; tgt_addr[k] = '0; tgt_wdata[k] = '0;
    end
    clear_stats();
    repeat (3) @(negedge clk);
    #2;
    check("rst_pmem_read", 0, pmem_read[0], 1'b0);
    check("rst_pmem_write", 0, pmem_write[0], 1'b0);
    check("rst_pmem_address", 0, pmem_address[0], 32'h0);
    check("rst_pmem_wdata", 0, pmem_wdata[0], 256'h0);
    #1 rst = 1'b1;
    clear_stats();

    // Lone icache read, L=5
    tgt_addr[0] = 32'h0000_1040; lat[0] = 5;
    @(negedge clk); #1;
    i_read[0] = 1'b1; i_address[0] = 32'h0000_1040;
    wait_quiet(60);
    check("t1_read_cycles_at_addr", 0, n_rd_hit[0], 5);
    check("t1_read_cycles", 0, n_rd[0], 5);
    check("t1_i_resp_pulses", 0, n_ir[0], 1);
    check("t1_d_resp_pulses", 0, n_dr[0], 0);

    // Simultaneous misses, fair, last_d=0 after reset: d then i
    do_reset();
    lat[0] = 3;
    @(negedge clk); #1;
    i_read[0] = 1'b1; i_address[0] = 32'h100;
    d_read[0] = 1'b1; d_address[0] = 32'h200;
    wait_quiet(80);
    check("t2_grants", 0, glog0.size(), 2);
    if (glog0.size() == 2) begin
      check("t2_grant0_is_d", 0, glog0[0], 1'b1);
      check("t2_grant1_is_i", 0, glog0[1], 1'b0);
    end
    check("t2_resps", 0, rlog0.size(), 2);
    if (rlog0.size() == 2) begin
      check("t2_resp0_is_d", 0, rlog0[0], 1'b1);
      check("t2_resp1_is_i", 0, rlog0[1], 1'b0);
    end

    // Write-back whose inputs change right after the grant
    do_reset();
    lat[0] = 4; tgt_addr[0] = 32'h300; tgt_wdata[0] = {32{8'hA5}};
    @(negedge clk); #1;
    d_write[0] = 1'b1; d_address[0] = 32'h300; d_wdata[0] = {32{8'hA5}};
    @(negedge clk); #1;
    d_address[0] = 32'h0000_BEE0; d_wdata[0] = rand_line();
    wait_quiet(60);
    check("t3_write_cycles_latched", 0, n_wr_hit[0], 4);
    check("t3_write_cycles", 0, n_wr[0], 4);
    check("t3_no_read", 0, n_rd[0], 0);
    check("t3_d_resp_pulses", 0, n_dr[0], 1);

    // Continuous contention on both instances
    do_reset();
    lat[0] = 2; lat[1] = 2; hold_i = 1; hold_d = 1;
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1'b1; i_address[k] = 32'h1000 + 32'(k);
      d_read[k] = 1'b1; d_address[k] = 32'h2000 + 32'(k);
    end
    for (int c = 0; c < 200 && (glog0.size() < 6 || glog1.size() < 6); c++) @(negedge clk);
    #1;
    hold_i = 0; hold_d = 0;
    drop_all();
    wait_quiet(60);
    check("t4_fair_count", 0, 32'(glog0.size() >= 6), 1);
    check("t4_fixed_count", 1, 32'(glog1.size() >= 6), 1);
    if (glog0.size() >= 6 && glog1.size() >= 6) begin
      for (int j = 0; j < 6; j++) begin
        check("t4_fair_grant", j, glog0[j], 1'((j % 2) == 0));
        check("t4_fixed_grant", j, glog1[j], 1'b1);
      end
    end

    // Reset two cycles into a dcache read
    do_reset();
    lat[0] = 10;
    @(negedge clk); #1;
    d_read[0] = 1'b1; d_address[0] = 32'h400;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0; d_read[0] = 1'b0; pmem_resp[0] = 1'b0; cnt[0] = 0;
    #1;
    check("t5_strobe_drops", 0, pmem_read[0], 1'b0);
    check("t5_no_d_resp", 0, d_resp[0], 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    check("t5_d_resp_total", 0, n_dr[0], 0);
    clear_stats();
    lat[0] = 3; tgt_addr[0] = 32'h0000_1040;
    @(negedge clk); #1;
    i_read[0] = 1'b1; i_address[0] = 32'h0000_1040;
    wait_quiet(60);
    check("t5_fresh_i_resp", 0, n_ir[0], 1);
    check("t5_fresh_read_cycles", 0, n_rd_hit[0], 3);

    // Illegal read+write is served as a write
    do_reset();
    lat[0] = 3; tgt_addr[0] = 32'h500; tgt_wdata[0] = rand_line();
    @(negedge clk); #1;
    d_read[0] = 1'b1; d_write[0] = 1'b1; d_address[0] = 32'h500; d_wdata[0] = tgt_wdata[0];
    wait_quiet(60);
    check("t6_write_cycles", 0, n_wr_hit[0], 3);
    check("t6_no_read", 0, n_rd[0], 0);
    check("t6_d_resp_pulses", 0, n_dr[0], 1);

    // Randomized traffic on both instances
    do_reset();
    lat_rand = 1; rand_en = 1;
    repeat (3000) @(negedge clk);
    #1 rand_en = 0;
    wait_quiet(200);
    check("rand_fair_activity", 0, 32'(glog0.size() > 50), 1);
    check("rand_fixed_activity", 1, 32'(glog1.size() > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
